// File: rtl/sound_pkg.sv
// Shared definitions for the piezo sound arbiter: state encoding, grant bit
// positions, note width and the source priority function.
package sound_pkg;

   localparam int NOTE_W = 13;
   localparam logic [NOTE_W-1:0] SILENCE = 13'd0;

   localparam int G_ALARM = 2;
   localparam int G_CLICK = 1;
   localparam int G_LULL  = 0;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      GAP       = 3'd1,
      SRV_ALARM = 3'd2,
      SRV_CLICK = 3'd3,
      SRV_LULL  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE,
      WIN_ALARM,
      WIN_CLICK,
      WIN_LULL
   } winner_t;

   // Fixed priority: alarm over click over lullaby.
   function automatic winner_t pick_winner(input logic alarm, input logic pending,
                                           input logic lull);
      if (alarm)        return WIN_ALARM;
      else if (pending) return WIN_CLICK;
      else if (lull)    return WIN_LULL;
      else              return WIN_NONE;
   endfunction

   function automatic state_t serve_state(input winner_t win);
      case (win)
         WIN_ALARM: return SRV_ALARM;
         WIN_CLICK: return SRV_CLICK;
         WIN_LULL:  return SRV_LULL;
         default:   return IDLE;
      endcase
   endfunction

endpackage

// File: rtl/sound_down_counter.sv
// Loadable down-counter with zero flag; shared by gap and click timing,
// which are never active at the same time.
module sound_down_counter #(
   parameter int CNT_W = 22
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   input  logic [CNT_W-1:0] load_value,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // Holds at zero instead of wrapping.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/sound_arbiter.sv
// Shares one piezo driver between alarm, keypad click and lullaby with a
// silence gap on every hand-over; the click tone is generated here.
module sound_arbiter
   import sound_pkg::*;
#(
   parameter int                 GAP_CYCLES = 50000,
   parameter int                 CLICK_LEN  = 2500000,
   parameter logic [NOTE_W-1:0]  CLICK_NOTE = 13'd1,
   parameter int                 CNT_W      = 22
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              alarm_req,
   input  logic [NOTE_W-1:0] alarm_beat,
   input  logic              lull_req,
   input  logic [NOTE_W-1:0] lull_beat,
   input  logic              click,
   input  logic              mute,
   output logic [NOTE_W-1:0] play_sound,
   output logic [2:0]        grant,
   output logic              click_busy
);

   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLICK_LOAD = CNT_W'(CLICK_LEN - 1);

   state_t           state;
   state_t           nxt;
   winner_t          winner;
   logic             click_pending;
   logic             enter_click;
   logic             cnt_load;
   logic             cnt_en;
   logic [CNT_W-1:0] cnt_value;
   logic             cnt_zero;

   assign winner = pick_winner(alarm_req, click_pending, lull_req);

   always_comb begin
      nxt       = state;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
      cnt_value = GAP_LOAD;
      case (state)
         IDLE: nxt = serve_state(winner);
         GAP: begin
            if (cnt_zero) nxt = serve_state(winner);
            else          cnt_en = 1'b1;
         end
         SRV_ALARM: begin
            if (!alarm_req) begin
               nxt      = GAP;
               cnt_load = 1'b1;
            end
         end
         SRV_CLICK: begin
            // A preempted click is dropped, not resumed.
            if (cnt_zero || alarm_req) begin
               nxt      = GAP;
               cnt_load = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         SRV_LULL: begin
            if (!lull_req || (winner == WIN_ALARM) || (winner == WIN_CLICK)) begin
               nxt      = GAP;
               cnt_load = 1'b1;
            end
         end
         default: nxt = IDLE;
      endcase
      enter_click = (nxt == SRV_CLICK) && (state != SRV_CLICK);
      if (enter_click) begin
         cnt_load  = 1'b1;
         cnt_value = CLICK_LOAD;
      end
   end

   sound_down_counter #(
      .CNT_W(CNT_W)
   ) u_counter (
      .clock      (clock),
      .reset      (reset),
      .load       (cnt_load),
      .enable     (cnt_en),
      .load_value (cnt_value),
      .zero       (cnt_zero)
   );

   // Outputs follow the state register, so they lag the state by one cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state         <= IDLE;
         click_pending <= 1'b0;
         play_sound    <= SILENCE;
         grant         <= 3'b000;
         click_busy    <= 1'b0;
      end else begin
         state <= nxt;
         if (enter_click)
            click_pending <= 1'b0;
         else if (click && (state != SRV_CLICK))
            click_pending <= 1'b1;

         click_busy <= click_pending || (state == SRV_CLICK);
         grant      <= 3'b000;
         play_sound <= SILENCE;
         case (state)
            SRV_ALARM: begin
               grant      <= 3'(1 << G_ALARM);
               play_sound <= alarm_beat;
            end
            SRV_CLICK: begin
               grant      <= 3'(1 << G_CLICK);
               play_sound <= mute ? SILENCE : CLICK_NOTE;
            end
            SRV_LULL: begin
               grant      <= 3'(1 << G_LULL);
               play_sound <= mute ? SILENCE : lull_beat;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter with a small gap and click length; the
// expected outputs of every cycle are queued and checked one cycle later.
module tb_sound_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        alarm_req;
   logic [12:0] alarm_beat;
   logic        lull_req;
   logic [12:0] lull_beat;
   logic        click;
   logic        mute;
   logic [12:0] play_sound;
   logic [2:0]  grant;
   logic        click_busy;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [2:0]  g;
      logic [12:0] p;
      logic        b;
      string       tag;
   } exp_t;

   exp_t sb[$];

   always #5 clock = ~clock;

   sound_arbiter #(
      .GAP_CYCLES (4),
      .CLICK_LEN  (6),
      .CLICK_NOTE (13'd1),
      .CNT_W      (22)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .alarm_req  (alarm_req),
      .alarm_beat (alarm_beat),
      .lull_req   (lull_req),
      .lull_beat  (lull_beat),
      .click      (click),
      .mute       (mute),
      .play_sound (play_sound),
      .grant      (grant),
      .click_busy (click_busy)
   );

   // Queue the outputs expected after the next edge, run the edge, then check.
   task automatic cyc(input logic [2:0] g, input logic [12:0] p, input logic b,
                      input string tag);
      exp_t e;
      e.g = g; e.p = p; e.b = b; e.tag = tag;
      sb.push_back(e);
      @(posedge clock);
      @(negedge clock);
      e = sb.pop_front();
      compared++;
      assert ({grant, play_sound, click_busy} === {e.g, e.p, e.b}) else begin
         mismatched++;
         $error("FAIL %s: observed grant=%b play=%0d busy=%b, expected grant=%b play=%0d busy=%b",
                e.tag, grant, play_sound, click_busy, e.g, e.p, e.b);
      end
   endtask

   initial begin
      reset = 1'b0; alarm_req = 1'b0; alarm_beat = 13'd0; lull_req = 1'b0;
      lull_beat = 13'd0; click = 1'b0; mute = 1'b0;

      // Reset, lullaby from idle without a gap, rest passthrough, reset mid-serve
      cyc(3'b000, 0, 0, "reset_state");
      cyc(3'b000, 0, 0, "reset_hold");
      reset = 1'b1; lull_req = 1'b1; lull_beat = 13'd55;
      cyc(3'b000, 0, 0, "lull_idle_edge");
      cyc(3'b001, 55, 0, "lull_grant");
      lull_beat = 13'd0;
      cyc(3'b001, 0, 0, "lull_rest");
      lull_beat = 13'd55;
      cyc(3'b001, 55, 0, "lull_resume");
      reset = 1'b0;
      cyc(3'b000, 0, 0, "reset_mid_serve");
      reset = 1'b1;
      cyc(3'b000, 0, 0, "relaunch_idle");
      cyc(3'b001, 55, 0, "relaunch_grant");

      // Click interrupts the lullaby, lullaby resumes afterwards
      click = 1'b1;
      cyc(3'b001, 55, 0, "click_capture");
      click = 1'b0;
      cyc(3'b001, 55, 1, "lull_to_gap");
      for (int i = 0; i < 4; i++) cyc(3'b000, 0, 1, "gap_before_click");
      for (int i = 0; i < 6; i++) cyc(3'b010, 1, 1, "click_tone");
      for (int i = 0; i < 4; i++) cyc(3'b000, 0, 0, "gap_after_click");
      cyc(3'b001, 55, 0, "lull_back");

      // Alarm preempts a click; the click is not replayed
      reset = 1'b0; lull_req = 1'b0;
      cyc(3'b000, 0, 0, "reset_t3");
      reset = 1'b1; click = 1'b1;
      cyc(3'b000, 0, 0, "click_idle_capture");
      click = 1'b0;
      cyc(3'b000, 0, 1, "click_start");
      cyc(3'b010, 1, 1, "click_pre1");
      cyc(3'b010, 1, 1, "click_pre2");
      alarm_req = 1'b1; alarm_beat = 13'd77;
      cyc(3'b010, 1, 1, "click_preempt_edge");
      for (int i = 0; i < 4; i++) cyc(3'b000, 0, 0, "gap_preempt");
      cyc(3'b100, 77, 0, "alarm_grant");
      alarm_beat = 13'd0;
      cyc(3'b100, 0, 0, "alarm_rest");
      alarm_beat = 13'd33;
      cyc(3'b100, 33, 0, "alarm_beat2");
      alarm_req = 1'b0;
      cyc(3'b100, 33, 0, "alarm_release");
      for (int i = 0; i < 4; i++) cyc(3'b000, 0, 0, "gap_after_alarm");
      cyc(3'b000, 0, 0, "no_click_replay");
      cyc(3'b000, 0, 0, "idle_hold");

      // Alarm and click together from idle: click deferred behind the alarm
      alarm_req = 1'b1; alarm_beat = 13'd88; click = 1'b1;
      cyc(3'b000, 0, 0, "simul_edge");
      click = 1'b0;
      cyc(3'b100, 88, 1, "simul_alarm");
      cyc(3'b100, 88, 1, "simul_alarm2");
      alarm_req = 1'b0;
      cyc(3'b100, 88, 1, "simul_release");
      for (int i = 0; i < 4; i++) cyc(3'b000, 0, 1, "gap_pending_click");
      for (int i = 0; i < 6; i++) cyc(3'b010, 1, 1, "deferred_click");
      for (int i = 0; i < 4; i++) cyc(3'b000, 0, 0, "gap_after_deferred");
      cyc(3'b000, 0, 0, "idle_after_deferred");

      // Mute silences the lullaby but never the alarm
      lull_req = 1'b1; lull_beat = 13'd55; mute = 1'b1;
      cyc(3'b000, 0, 0, "mute_idle_edge");
      cyc(3'b001, 0, 0, "mute_lull");
      mute = 1'b0;
      cyc(3'b001, 55, 0, "unmute_lull");
      mute = 1'b1; alarm_req = 1'b1; alarm_beat = 13'd99;
      cyc(3'b001, 0, 0, "lull_preempt_edge");
      for (int i = 0; i < 4; i++) cyc(3'b000, 0, 0, "gap_to_alarm");
      cyc(3'b100, 99, 0, "alarm_under_mute");
      cyc(3'b100, 99, 0, "alarm_under_mute2");
      alarm_req = 1'b0; lull_req = 1'b0; mute = 1'b0;
      cyc(3'b100, 99, 0, "alarm_release2");
      for (int i = 0; i < 4; i++) cyc(3'b000, 0, 0, "gap_to_idle");
      cyc(3'b000, 0, 0, "idle_t5");

      // Clicks during a serve merge; a click during the following gap plays next
      click = 1'b1;
      cyc(3'b000, 0, 0, "c6_capture");
      click = 1'b0;
      cyc(3'b000, 0, 1, "c6_start");
      cyc(3'b010, 1, 1, "c6_tone");
      click = 1'b1;
      cyc(3'b010, 1, 1, "c6_merge1");
      click = 1'b0;
      cyc(3'b010, 1, 1, "c6_tone");
      click = 1'b1;
      cyc(3'b010, 1, 1, "c6_merge2");
      click = 1'b0;
      cyc(3'b010, 1, 1, "c6_tone");
      click = 1'b1;
      cyc(3'b010, 1, 1, "c6_merge3");
      click = 1'b0;
      cyc(3'b000, 0, 0, "c6_gap");
      cyc(3'b000, 0, 0, "c6_gap");
      click = 1'b1;
      cyc(3'b000, 0, 0, "c6_gap_click");
      click = 1'b0;
      cyc(3'b000, 0, 1, "c6_gap_end");
      for (int i = 0; i < 6; i++) cyc(3'b010, 1, 1, "c6_second_tone");
      for (int i = 0; i < 4; i++) cyc(3'b000, 0, 0, "c6_final_gap");
      cyc(3'b000, 0, 0, "c6_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
